// File: rtl/interconnect_pkg.sv
// Shared types and constants for the shared-slave interconnect mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package interconnect_pkg;

  localparam int NUM_MASTERS        = 4;
  localparam int IDX_W              = $clog2(NUM_MASTERS);
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } mux_state_t;

  // Expand a master index back into its one-hot completion vector.
  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot      = '0;
    idx_to_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Converts the 4-bit one-hot grant into a master index plus an exactly-one-set flag.
// Latency: combinational.
// Backpressure: none; pure decode.
module onehot_to_idx
  import interconnect_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] onehot,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  // Priority-encode the lowest set bit; only meaningful when valid is high.
  always_comb begin
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign valid = (onehot != '0) &&
                 ((onehot & (onehot - NUM_MASTERS'(1))) == '0);

endmodule

// File: rtl/interconnect_mux.sv
// Routes the granted master's request to one shared slave and returns completion/read data.
// Latency: grant -> S_VALID 1 cycle; write done 2 cycles, read done 3 cycles with ready/rvalid immediate.
// Backpressure: holds the captured request on S_VALID until S_READY; optional watchdog via INTERCONNECT_TIMEOUT_EN.
module interconnect_mux
  import interconnect_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        GNT,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_ADDR,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_WDATA,
  input  logic [NUM_MASTERS-1:0]        M_WR,
  output logic [NUM_MASTERS-1:0]        M_DONE,
  output logic [DATA_W-1:0]             M_RDATA,
  output logic                          M_ERR,
  output logic                          S_VALID,
  output logic [ADDR_W-1:0]             S_ADDR,
  output logic [DATA_W-1:0]             S_WDATA,
  output logic                          S_WR,
  input  logic                          S_READY,
  input  logic                          S_RVALID,
  input  logic [DATA_W-1:0]             S_RDATA
);

  mux_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             to_fire;

  onehot_to_idx u_gnt_dec (
    .onehot (GNT),
    .idx    (gnt_idx),
    .valid  (gnt_vld)
  );

`ifdef INTERCONNECT_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Watchdog: zero while idle (so it starts from 0 on ISSUE entry), counts in ISSUE/RESP, saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if ((state == ISSUE || state == RESP) && wd_cnt != CNT_MAX) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // The counter reaches its limit on the edge that moves us to DONE; a slave handshake on that edge wins.
  assign to_fire = (wd_cnt >= CNT_LAST) &&
                   ((state == ISSUE && !S_READY) || (state == RESP && !S_RVALID));

  // Error flag is high only in the DONE cycle produced by a watchdog expiry.
  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= to_fire;
  end

  assign M_ERR = err_q;
`else
  // Keeps the watchdog limit part of the interface even when no watchdog is built.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign to_fire = 1'b0;
  assign M_ERR   = 1'b0;
`endif

  // Transaction FSM: capture grant, issue to slave, collect read data, pulse completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      S_VALID <= 1'b0;
      S_ADDR  <= '0;
      S_WDATA <= '0;
      S_WR    <= 1'b0;
      M_DONE  <= '0;
      M_RDATA <= '0;
    end else begin
      M_DONE <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            idx     <= gnt_idx;
            S_ADDR  <= M_ADDR[gnt_idx*ADDR_W +: ADDR_W];
            S_WDATA <= M_WDATA[gnt_idx*DATA_W +: DATA_W];
            S_WR    <= M_WR[gnt_idx];
            S_VALID <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (S_READY) begin
            S_VALID <= 1'b0;
            if (S_WR) begin
              M_DONE  <= idx_to_onehot(idx);
              M_RDATA <= '0;
              state   <= DONE;
            end else begin
              state   <= RESP;
            end
          end else if (to_fire) begin
            S_VALID <= 1'b0;
            M_DONE  <= idx_to_onehot(idx);
            M_RDATA <= '0;
            state   <= DONE;
          end
        end
        RESP: begin
          if (S_RVALID) begin
            M_DONE  <= idx_to_onehot(idx);
            M_RDATA <= S_RDATA;
            state   <= DONE;
          end else if (to_fire) begin
            M_DONE  <= idx_to_onehot(idx);
            M_RDATA <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interconnect_mux.sv
// Self-checking bench for interconnect_mux: table of transactions plus reset/timeout sequences.
// Latency: checks grant->S_VALID, write/read completion cycle counts.
// Backpressure: exercises S_READY stalls with grant churn, late/early S_RVALID.
module tb_interconnect_mux;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    GNT = '0;
  logic [4*AW-1:0] M_ADDR = '0;
  logic [4*DW-1:0] M_WDATA = '0;
  logic [3:0]    M_WR = '0;
  logic [3:0]    M_DONE;
  logic [DW-1:0] M_RDATA;
  logic          M_ERR;
  logic          S_VALID;
  logic [AW-1:0] S_ADDR;
  logic [DW-1:0] S_WDATA;
  logic          S_WR;
  logic          S_READY = 1'b0;
  logic          S_RVALID = 1'b0;
  logic [DW-1:0] S_RDATA = '0;

  always #5 clk = ~clk;

  interconnect_mux #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .GNT(GNT), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_WR(M_WR), .M_DONE(M_DONE), .M_RDATA(M_RDATA), .M_ERR(M_ERR),
    .S_VALID(S_VALID), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA), .S_WR(S_WR),
    .S_READY(S_READY), .S_RVALID(S_RVALID), .S_RDATA(S_RDATA)
  );

  typedef struct {
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         rdy_dly;
    int         rv_dly;
    logic [3:0] exp_done;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [3:0] done;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   nvec = 0;
  int   nbad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   g;
    int   cyc;
    bit   seen;
    exp_t e;
    g = 0;
    for (int i = 0; i < 4; i++) if (v.gnt[i]) g = i;
    for (int i = 0; i < 4; i++) begin
      M_ADDR[i*AW +: AW]  = (i == g) ? v.addr : ~v.addr;
      M_WDATA[i*DW +: DW] = (i == g) ? v.wdata : ~v.wdata;
      M_WR[i]             = (i == g) ? v.wr : ~v.wr;
    end
    GNT      = v.gnt;
    S_READY  = (v.rdy_dly == 0);
    S_RVALID = 1'b0;
    if (v.exp_done == 4'b0000) begin
      repeat (3) begin
        tick();
        chk("idle_svalid", 32'(S_VALID), 32'd0);
      end
      chk("idle_mdone", 32'(M_DONE), 32'd0);
      GNT = '0;
      return;
    end
    sb.push_back('{v.exp_done, (v.wr ? 8'h00 : v.rdata), 1'b0, v.exp_lat});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (M_DONE != 4'b0000) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("done_vec", 32'(M_DONE), 32'(e.done));
        chk("done_rdata", 32'(M_RDATA), 32'(e.rdata));
        chk("done_err", 32'(M_ERR), 32'(e.err));
        chk("done_lat", 32'(cyc), 32'(e.lat));
      end else if (cyc <= v.rdy_dly + 1) begin
        chk("issue_svalid", 32'(S_VALID), 32'd1);
        chk("issue_saddr", 32'(S_ADDR), 32'(v.addr));
        chk("issue_swdata", 32'(S_WDATA), 32'(v.wdata));
        chk("issue_swr", 32'(S_WR), 32'(v.wr));
      end else begin
        chk("resp_svalid", 32'(S_VALID), 32'd0);
      end
      // Churn grant and master fields; they must not disturb the captured request.
      GNT      = seen ? 4'b0000 : 4'(4'b0001 << (cyc % 3));
      M_ADDR   = $urandom;
      M_WDATA  = $urandom;
      M_WR     = 4'($urandom);
      S_READY  = !seen && (cyc >= v.rdy_dly + 1);
      S_RVALID = !seen && !v.wr &&
                 ((cyc == 2 + v.rdy_dly + v.rv_dly) || (cyc == 1 && v.rdy_dly > 0));
      S_RDATA  = (cyc == 2 + v.rdy_dly + v.rv_dly) ? v.rdata : 8'hEE;
    end
    if (!seen) begin
      nvec++;
      nbad++;
      $display("FAIL done_wait: no M_DONE within 40 cycles, want %b", v.exp_done);
      void'(sb.pop_front());
    end
    GNT      = '0;
    S_READY  = 1'b0;
    S_RVALID = 1'b0;
    tick();
    chk("post_mdone", 32'(M_DONE), 32'd0);
    chk("post_rdata_hold", 32'(M_RDATA), 32'(v.wr ? 8'h00 : v.rdata));
    chk("post_svalid", 32'(S_VALID), 32'd0);
  endtask

  initial begin
    int cyc;
    //           gnt      wr    addr   wdata  rdata  rdy rv  done     lat
    tbl[0]  = '{4'b0010, 1'b1, 8'h3C, 8'hA5, 8'h00, 0,  0, 4'b0010, 2};
    tbl[1]  = '{4'b1000, 1'b0, 8'h77, 8'h00, 8'h5A, 0,  0, 4'b1000, 3};
    tbl[2]  = '{4'b0001, 1'b1, 8'h11, 8'h22, 8'h00, 5,  0, 4'b0001, 7};
    tbl[3]  = '{4'b0110, 1'b1, 8'h44, 8'h55, 8'h00, 0,  0, 4'b0000, 0};
    tbl[4]  = '{4'b0000, 1'b0, 8'h66, 8'h77, 8'h00, 0,  0, 4'b0000, 0};
    tbl[5]  = '{4'b0100, 1'b0, 8'hC3, 8'h99, 8'hE1, 2,  3, 4'b0100, 8};
    tbl[6]  = '{4'b0001, 1'b0, 8'h00, 8'hFF, 8'h0F, 1,  1, 4'b0001, 5};
    tbl[7]  = '{4'b1000, 1'b1, 8'hFF, 8'h00, 8'h00, 0,  0, 4'b1000, 2};
    tbl[8]  = '{4'b1111, 1'b0, 8'h12, 8'h34, 8'h00, 0,  0, 4'b0000, 0};
    tbl[9]  = '{4'b0100, 1'b1, 8'h80, 8'h01, 8'h00, 3,  0, 4'b0100, 5};
    tbl[10] = '{4'b0010, 1'b0, 8'h01, 8'h02, 8'h3C, 0,  2, 4'b0010, 5};
    // Slave ready lands exactly in the last watchdog cycle: handshake wins, no error.
    tbl[11] = '{4'b0010, 1'b1, 8'h9A, 8'hBC, 8'h00, TO-1, 0, 4'b0010, TO+1};

    // Reset state
    repeat (3) tick();
    chk("rst_svalid", 32'(S_VALID), 32'd0);
    chk("rst_mdone", 32'(M_DONE), 32'd0);
    chk("rst_merr", 32'(M_ERR), 32'd0);
    chk("rst_mrdata", 32'(M_RDATA), 32'd0);
    chk("rst_saddr", 32'(S_ADDR), 32'd0);
    chk("rst_swdata", 32'(S_WDATA), 32'd0);
    chk("rst_swr", 32'(S_WR), 32'd0);
    reset = 1'b1;
    tick();

    // Table; consecutive accepted rows are issued back-to-back right after DONE.
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Reset while waiting in RESP aborts the read.
    M_ADDR   = {8'h00, 8'h5D, 8'h00, 8'h00};
    M_WR     = 4'b0000;
    GNT      = 4'b0100;
    S_READY  = 1'b1;
    tick();
    chk("rr_issue_svalid", 32'(S_VALID), 32'd1);
    GNT = '0;
    tick();
    chk("rr_resp_svalid", 32'(S_VALID), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rr_svalid", 32'(S_VALID), 32'd0);
    chk("rr_mdone", 32'(M_DONE), 32'd0);
    chk("rr_saddr", 32'(S_ADDR), 32'd0);
    chk("rr_mrdata", 32'(M_RDATA), 32'd0);
    S_READY  = 1'b0;
    S_RVALID = 1'b1;
    S_RDATA  = 8'hAB;
    repeat (3) begin
      tick();
      chk("rr_late_rvalid_mdone", 32'(M_DONE), 32'd0);
      chk("rr_late_rvalid_svalid", 32'(S_VALID), 32'd0);
    end
    S_RVALID = 1'b0;
    // Block is back in IDLE and serves a fresh write.
    run_vec('{4'b0001, 1'b1, 8'h2E, 8'h4F, 8'h00, 0, 0, 4'b0001, 2});

`ifdef INTERCONNECT_TIMEOUT_EN
    // Slave never ready: watchdog completes with error at cycle 1+TO.
    M_ADDR  = {4{8'h42}};
    M_WR    = 4'b1111;
    GNT     = 4'b0001;
    S_READY = 1'b0;
    cyc = 0;
    while (M_DONE == 4'b0000 && cyc < 60) begin
      tick();
      cyc++;
      GNT = '0;
      if (M_DONE == 4'b0000) chk("to_wait_merr", 32'(M_ERR), 32'd0);
    end
    chk("to_lat", 32'(cyc), 32'(1 + TO));
    chk("to_mdone", 32'(M_DONE), 32'b0001);
    chk("to_merr", 32'(M_ERR), 32'd1);
    chk("to_mrdata", 32'(M_RDATA), 32'd0);
    chk("to_svalid", 32'(S_VALID), 32'd0);
    tick();
    chk("to_post_merr", 32'(M_ERR), 32'd0);
    chk("to_post_mdone", 32'(M_DONE), 32'd0);
`else
    // No watchdog: a long stall still completes normally without error.
    cyc = 0;
    run_vec('{4'b0100, 1'b1, 8'h5C, 8'h6D, 8'h00, 30, 0, 4'b0100, 32});
    chk("nowd_merr", 32'(M_ERR), 32'(cyc));
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
